// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core types and constants for the fetch stage
package cpu_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} fetch_state_t;
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
   } ifid_t;
endpackage

// File: rtl/fetch_skid_reg.sv
// fetch_skid_reg: single-entry buffer parking a response that arrived during a decode stall
module fetch_skid_reg
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic            clear_i,
   input  logic [XLEN-1:0] instr_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] pc4_i,
   output ifid_t           entry_o
);
   ifid_t entry_q, entry_d;
   // load wins over clear; clear only drops the valid bit
   always_comb
      entry_d = load_i ? '{1'b1, instr_i, pc_i, pc4_i}
                       : '{entry_q.valid & ~clear_i, entry_q.instr, entry_q.pc, entry_q.pc4};
   // storage
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) entry_q <= '0;
      else        entry_q <= entry_d;
   assign entry_o = entry_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC owner and single-outstanding imem fetcher feeding the IF/ID register
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] pc_o,
   input  logic [31:0] pc_plus4_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        if_valid_o,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_pc4_o
);
   import cpu_pkg::*;
   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            req_q, req_d;
   ifid_t           ifid_q, ifid_d, skid, bubble;
   logic            skid_load, skid_clear, granted, outstanding;
   logic [XLEN-1:0] redirect_tgt;
   assign redirect_tgt = redirect_pc_i & ~32'h3;
   // req_q is only high while in S_REQ, so it doubles as "request presented"
   assign granted     = req_q & imem_gnt_i;
   assign outstanding = granted | (((state_q == S_WAIT) | (state_q == S_DROP)) & ~imem_rvalid_i);
   assign bubble      = '{1'b0, NOP_INSTR, ifid_q.pc, ifid_q.pc4};
   fetch_skid_reg u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .instr_i (imem_rdata_i),
      .pc_i    (pc_q),
      .pc4_i   (pc_plus4_i),
      .entry_o (skid)
   );
   // next-state: handshake progress first, then redirect overrides everything
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ifid_d     = stall_i ? ifid_q : bubble;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      case (state_q)
         S_REQ:  state_d = granted ? S_WAIT : S_REQ;
         S_WAIT: if (imem_rvalid_i) begin
            pc_d      = pc_plus4_i;
            skid_load = stall_i;
            ifid_d    = stall_i ? ifid_q : '{1'b1, imem_rdata_i, pc_q, pc_plus4_i};
            state_d   = stall_i ? S_HOLD : S_REQ;
         end
         S_HOLD: if (!stall_i) begin
            ifid_d     = skid;
            skid_clear = 1'b1;
            state_d    = S_REQ;
         end
         default: state_d = imem_rvalid_i ? S_REQ : S_DROP;
      endcase
      if (redirect_i) begin
         pc_d       = redirect_tgt;
         ifid_d     = bubble;
         skid_load  = 1'b0;
         skid_clear = 1'b1;
         state_d    = outstanding ? S_DROP : S_REQ;
      end
      req_d = state_d == S_REQ;
   end
   // all fetch-stage state, outputs registered
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         ifid_q  <= '{1'b0, NOP_INSTR, 32'h0, 32'h0};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         ifid_q  <= ifid_d;
      end
   assign pc_o        = pc_q;
   assign imem_addr_o = pc_q;
   assign imem_req_o  = req_q;
   assign if_valid_o  = ifid_q.valid;
   assign if_instr_o  = ifid_q.instr;
   assign if_pc_o     = ifid_q.pc;
   assign if_pc4_o    = ifid_q.pc4;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed fetch scenarios checked against a transaction-level model
module tb_pc_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i, redirect_i, imem_gnt_i, imem_rvalid_i;
   logic [31:0] redirect_pc_i, imem_rdata_i, pc_plus4_i;
   logic [31:0] pc_o, imem_addr_o, if_instr_o, if_pc_o, if_pc4_o;
   logic        imem_req_o, if_valid_o;
   int          errors = 0;
   int          checks = 0;
   logic        started = 1'b0;
   logic [31:0] last_gnt_addr = 32'h0;
   // model: request/outstanding/stale/held view of the fetch stage
   logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, h_instr, h_pc, h_pc4;
   logic        m_req, m_out, m_stale, m_held, m_valid;
   pc_fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .pc_o          (pc_o),
      .pc_plus4_i    (pc_plus4_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .if_valid_o    (if_valid_o),
      .if_instr_o    (if_instr_o),
      .if_pc_o       (if_pc_o),
      .if_pc4_o      (if_pc4_o)
   );
   assign pc_plus4_i = pc_o + 32'd4;
   always #5 clk = ~clk;
   function automatic logic [31:0] code(input logic [31:0] a);
      return 32'h0000_0093 + (a << 8);
   endfunction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc = 32'h0; m_req = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_held = 1'b0;
         m_valid = 1'b0; m_instr = NOP; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
      end else begin
         automatic logic acc  = m_req & imem_gnt_i;
         automatic logic resp = m_out & imem_rvalid_i;
         if (redirect_i) begin
            m_pc = {redirect_pc_i[31:2], 2'b00};
            m_valid = 1'b0; m_instr = NOP; m_held = 1'b0;
            m_out = acc | (m_out & ~imem_rvalid_i);
            m_stale = m_out;
         end else begin
            automatic logic was_held = m_held;
            if (!stall_i) begin m_valid = 1'b0; m_instr = NOP; end
            if (resp && !m_stale) begin
               if (stall_i) begin
                  m_held = 1'b1; h_instr = imem_rdata_i; h_pc = m_pc; h_pc4 = m_pc + 32'd4;
               end else begin
                  m_valid = 1'b1; m_instr = imem_rdata_i; m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
               end
               m_pc = m_pc + 32'd4;
            end
            if (was_held && !stall_i) begin
               m_valid = 1'b1; m_instr = h_instr; m_ifpc = h_pc; m_ifpc4 = h_pc4; m_held = 1'b0;
            end
            if (resp) m_stale = 1'b0;
            m_out = acc | (m_out & ~imem_rvalid_i);
         end
         m_req = ~m_out & ~m_held;
      end
   end
   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask
   always @(negedge clk) if (started) begin
      cmp("pc_o", pc_o, m_pc);
      cmp("imem_addr_o", imem_addr_o, m_pc);
      cmp("imem_req_o", {31'h0, imem_req_o}, {31'h0, m_req});
      cmp("if_valid_o", {31'h0, if_valid_o}, {31'h0, m_valid});
      cmp("if_instr_o", if_instr_o, m_instr);
      if (m_valid) begin
         cmp("if_pc_o", if_pc_o, m_ifpc);
         cmp("if_pc4_o", if_pc4_o, m_ifpc4);
      end
   end
   task automatic cyc(input logic g, input logic rv, input logic st, input logic rd, input logic [31:0] tgt);
      @(negedge clk);
      #1;
      imem_gnt_i = g; imem_rvalid_i = rv; stall_i = st; redirect_i = rd; redirect_pc_i = tgt;
      imem_rdata_i = rv ? code(last_gnt_addr) : 32'hDEAD_BEEF;
      if (g && imem_req_o) last_gnt_addr = imem_addr_o;
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst_n = 1'b0; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
      imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
      repeat (2) @(posedge clk);
      #1;
      cmp("rst pc_o", pc_o, 32'h0);
      cmp("rst req", {31'h0, imem_req_o}, 32'h0);
      cmp("rst valid", {31'h0, if_valid_o}, 32'h0);
      cmp("rst instr", if_instr_o, NOP);
      cmp("rst if_pc", if_pc_o, 32'h0);
      cmp("rst if_pc4", if_pc4_o, 32'h0);
      rst_n = 1'b1; started = 1'b1;
      // reset and first fetch
      cyc(0, 0, 0, 0, 0);
      cmp("t1 req", {31'h0, imem_req_o}, 32'h1);
      cmp("t1 addr", imem_addr_o, 32'h0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cmp("t1 valid", {31'h0, if_valid_o}, 32'h1);
      cmp("t1 instr", if_instr_o, 32'h0000_0093);
      cmp("t1 if_pc", if_pc_o, 32'h0);
      cmp("t1 if_pc4", if_pc4_o, 32'h4);
      cmp("t1 next addr", imem_addr_o, 32'h4);
      // stall on response
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(1, 0, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      cmp("t2 held pc", if_pc_o, 32'h4);
      cmp("t2 req", {31'h0, imem_req_o}, 32'h0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cmp("t2 if_pc", if_pc_o, 32'h8);
      cmp("t2 instr", if_instr_o, code(32'h8));
      cmp("t2 addr", imem_addr_o, 32'hC);
      // redirect while outstanding
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 32'h0000_0103);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cmp("t3 valid", {31'h0, if_valid_o}, 32'h0);
      cmp("t3 addr", imem_addr_o, 32'h100);
      cmp("t3 req", {31'h0, imem_req_o}, 32'h1);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cmp("t3 if_pc", if_pc_o, 32'h100);
      // redirect and rvalid together
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 1, 32'h0000_0200);
      cmp("t4 valid", {31'h0, if_valid_o}, 32'h0);
      cmp("t4 req", {31'h0, imem_req_o}, 32'h1);
      cmp("t4 addr", imem_addr_o, 32'h200);
      // redirect beats stall with full skid
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(1, 0, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      cyc(0, 0, 1, 1, 32'h0000_0300);
      cmp("t5 valid", {31'h0, if_valid_o}, 32'h0);
      cmp("t5 addr", imem_addr_o, 32'h300);
      cyc(0, 0, 0, 0, 0);
      cmp("t5 valid2", {31'h0, if_valid_o}, 32'h0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cmp("t5 if_pc", if_pc_o, 32'h300);
      // grant delay and wrap
      cyc(0, 0, 0, 1, 32'hFFFF_FFFF);
      repeat (4) cyc(0, 0, 0, 0, 0);
      cmp("t6 addr", imem_addr_o, 32'hFFFF_FFFC);
      cmp("t6 req", {31'h0, imem_req_o}, 32'h1);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cmp("t6 if_pc", if_pc_o, 32'hFFFF_FFFC);
      cmp("t6 if_pc4", if_pc4_o, 32'h0);
      cmp("t6 wrap addr", imem_addr_o, 32'h0);
      // redirect in the grant cycle waits out the stale response
      cyc(1, 0, 0, 1, 32'h0000_0400);
      cmp("t7 req", {31'h0, imem_req_o}, 32'h0);
      cyc(0, 1, 0, 0, 0);
      cmp("t7 valid", {31'h0, if_valid_o}, 32'h0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cmp("t7 if_pc", if_pc_o, 32'h400);
      // asynchronous reset mid-transaction
      cyc(1, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      cmp("t8 pc", pc_o, 32'h0);
      cmp("t8 req", {31'h0, imem_req_o}, 32'h0);
      cmp("t8 valid", {31'h0, if_valid_o}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cmp("t8 instr", if_instr_o, 32'h0000_0093);
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
